note_detector: RTL and testbench
================================

Name: note_detector

Overview:
Receive-side counterpart to the piano's per-note square-wave generators. It takes a square wave (`tone_in`) from an external pin or from a generator output, and measures its period in 50 MHz clock cycles. It then classifies the period against the 12-note C4..B4 table and reports a stable note index once the input has locked. It sits between the tone source and the display/self-test logic, and verifies that each generator produces the correct pitch.

Parameters:
- LOCK_COUNT, 3: consecutive matching periods required to assert a note.
- UNLOCK_COUNT, 2: consecutive non-matching periods required to drop a locked note.
- TOL, 2048: allowed |period - table entry|, in clock cycles.
- TIMEOUT, 200000: cycles without a rising edge before the input is declared silent.
- CNT_W, 18: width of the period counter and of `period`.

Ports:
- clk, input, 1: 50 MHz system clock.
- reset, input, 1: synchronous, active-high reset.
- tone_in, input, 1: asynchronous square wave under test.
- note_valid, output, 1: a note is locked.
- note_idx, output, 4: locked note; 0=C4 .. 9=A4, 10=A#4, 11=B4.
- period, output, CNT_W: last measured full period, in cycles.
- note_change, output, 1: one-cycle pulse when a new note locks.

Behaviour:
- Reset (synchronous, active-high; one clock; reset is synchronous and active-high) sets:
  - note_valid=0, note_idx=0, period=0, note_change=0;
  - counter=0, match_cnt=0, miss_cnt=0, candidate=0;
  - state=SILENT.
- Input path: `tone_in` passes through a 2-FF synchronizer, then a rising-edge detector. `rise` is a one-cycle pulse, 3 clocks after the transition is sampled.
- Counter:
  - Increments every cycle. It is set to 0 on the cycle `rise` is high.
  - It saturates at TIMEOUT.
  - Measured period at `rise` = counter+1, i.e. cycles between consecutive `rise` pulses.
- Note table: P_i = 2*(floor(25000000/f_i)+1):
  - C4 190840, C#4 180506, D4 170070, D#4 160772
  - E4 151516, F4 143268, F#4 135136, G4 127552
  - G#4 120482, A4 113638, A#4 107298, B4 101216
- Classification is combinational on the measured period.
  - match = some i with |period - P_i| <= TOL; the lowest i wins.
  - No match gives class = NONE.
- States:
  - SILENT:
    - On `rise` → ARMED. No period is recorded; this first edge only starts timing.
  - ARMED:
    - On `rise`, `period` is registered.
    - If class == candidate and match_cnt > 0, then match_cnt++. Else if class != NONE, then candidate = class and match_cnt = 1. Else match_cnt = 0.
    - When match_cnt reaches LOCK_COUNT: → LOCKED, note_valid=1, note_idx=candidate.
    - note_change=1 for that cycle, only if note_idx differs from the previously locked note or valid was 0.
  - LOCKED:
    - On `rise`, `period` is registered.
    - class == note_idx → miss_cnt = 0.
    - Otherwise miss_cnt++.
    - When miss_cnt reaches UNLOCK_COUNT: → ARMED, note_valid=0, miss_cnt=0. candidate = the current class; match_cnt = 1 if class != NONE, else 0.
  - Any non-SILENT state: counter == TIMEOUT → SILENT. note_valid=0, match_cnt=0, miss_cnt=0. `period` and `note_idx` hold their values.
- Timing of outputs: they update on the clock edge that samples `rise`, which is ≤4 clk after the `tone_in` rise.
- Simultaneous events:
  - `rise` and TIMEOUT in the same cycle: `rise` wins.
  - `reset` overrides everything.
- Reset mid-lock: outputs clear on the next edge, and the next `rise` re-arms.
- A period > 2^CNT_W-1 cannot occur, because TIMEOUT < 2^CNT_W.

Decomposition:
- Package `note_pkg` holds:
  - CLK_HZ=50000000 and NUM_NOTES=12;
  - the note period constant array P_i;
  - the note index enum;
  - the state enum (SILENT, ARMED, LOCKED).
- Sub-module `tone_sync_edge` holds the 2-FF synchronizer plus rising-edge pulse; it is reused by the keyboard inputs.

Test Plan:
1. Ideal A#4 wave, half-period 53649 cycles → at the 4th rise: note_valid=1, note_idx=10, period=107298, note_change pulses once.
2. Lock on A#4, then switch to B4 (half 50608) → valid drops after the 2nd B4 period. It relocks with idx=11 after 2 more B4 periods (the 1st mismatch seeds the candidate). note_change pulses.
3. Lock on C4, then hold `tone_in` low → exactly 200000 cycles after the last `rise`: note_valid=0, state SILENT, period holds 190840.
4. Periods of 110000 (outside TOL of both A4 and A#4) → note_valid stays 0 indefinitely; period=110000.
5. A4 with periods alternating 113638±1500 → locks idx=9. One injected 120482 period does not drop the lock (miss_cnt=1 < 2).
6. Assert reset for 1 cycle while locked on G4 → the next cycle has note_valid=0, note_idx=0, period=0. The wave continues, and it relocks 4 rises later.

Source files
------------

// File: rtl/note_pkg.sv
// Shared definitions for the note detector: clock rate, note table,
// note index and detector state encodings, period classifier.
package note_pkg;

  localparam int unsigned CLK_HZ    = 50000000;
  localparam int unsigned NUM_NOTES = 12;

  typedef enum logic [3:0] {
    NOTE_C4   = 4'd0,
    NOTE_CS4  = 4'd1,
    NOTE_D4   = 4'd2,
    NOTE_DS4  = 4'd3,
    NOTE_E4   = 4'd4,
    NOTE_F4   = 4'd5,
    NOTE_FS4  = 4'd6,
    NOTE_G4   = 4'd7,
    NOTE_GS4  = 4'd8,
    NOTE_A4   = 4'd9,
    NOTE_AS4  = 4'd10,
    NOTE_B4   = 4'd11,
    NOTE_NONE = 4'd15
  } note_e;

  typedef enum logic [1:0] {
    SILENT = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Full-wave period of each generator, in CLK_HZ cycles: 2*(floor(25e6/f)+1)
  localparam int unsigned NOTE_PERIOD [NUM_NOTES] = '{
    190840, 180506, 170070, 160772,
    151516, 143268, 135136, 127552,
    120482, 113638, 107298, 101216
  };

  // Lowest-indexed note whose period lies within tol cycles, else NOTE_NONE
  function automatic note_e classify(input int unsigned per, input int unsigned tol);
    note_e       cls;
    int unsigned diff;
    cls = NOTE_NONE;
    for (int unsigned i = 0; i < NUM_NOTES; i++) begin
      diff = (per > NOTE_PERIOD[i]) ? (per - NOTE_PERIOD[i]) : (NOTE_PERIOD[i] - per);
      if ((cls == NOTE_NONE) && (diff <= tol)) begin
        cls = note_e'(i[3:0]);
      end
    end
    return cls;
  endfunction

endpackage

// File: rtl/note_detector_if.sv
// Tone input and note-report outputs of the note detector.
interface note_detector_if #(
  parameter int unsigned CNT_W = 18
);
  logic             tone_in;
  logic             note_valid;
  logic [3:0]       note_idx;
  logic [CNT_W-1:0] period;
  logic             note_change;

  modport master (
    output tone_in,
    input  note_valid, note_idx, period, note_change
  );

  modport slave (
    input  tone_in,
    output note_valid, note_idx, period, note_change
  );
endinterface

// File: rtl/tone_sync_edge.sv
// 2-FF synchronizer for an asynchronous input plus a registered
// one-cycle rising-edge pulse.
module tone_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic rise
);

  logic s1_q, s2_q, prev_q;
  logic rise_d, rise_q;

  // Edge detect on the synchronized level
  always_comb begin
    rise_d = s2_q & ~prev_q;
  end

  // Synchronizer/history chain is left free-running through reset so a
  // steady-high input is not mistaken for a fresh edge once reset drops
  always_ff @(posedge clk) begin
    s1_q   <= d_in;
    s2_q   <= s1_q;
    prev_q <= s2_q;
  end

  // Registered edge pulse, suppressed during reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/note_detector.sv
// Measures the period of tone_in and reports a locked C4..B4 note index.
module note_detector #(
  parameter int unsigned LOCK_COUNT   = 3,
  parameter int unsigned UNLOCK_COUNT = 2,
  parameter int unsigned TOL          = 2048,
  parameter int unsigned TIMEOUT      = 200000,
  parameter int unsigned CNT_W        = 18
) (
  input  logic            clk,
  input  logic            reset,
  note_detector_if.slave  bus
);

  import note_pkg::*;

  localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);
  localparam logic [7:0]       LOCK_N   = 8'(LOCK_COUNT);
  localparam logic [7:0]       UNLOCK_N = 8'(UNLOCK_COUNT);

  logic             rise;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] meas;
  note_e            cls;
  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  note_e            idx_q, idx_d;
  logic             change_q, change_d;
  note_e            cand_q, cand_d;
  logic [7:0]       match_q, match_d;
  logic [7:0]       miss_q, miss_d;

  tone_sync_edge u_sync (
    .clk   (clk),
    .reset (reset),
    .d_in  (bus.tone_in),
    .rise  (rise)
  );

  // Period counter: cleared on rise, saturating at TIMEOUT; classify counter+1
  always_comb begin
    counter_d = counter_q;
    if (rise) begin
      counter_d = '0;
    end else if (counter_q != TMO) begin
      counter_d = counter_q + CNT_W'(1);
    end
    meas = counter_q + CNT_W'(1);
    cls  = classify(32'(meas), TOL);
  end

  // Lock FSM: next state and output/register updates
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    change_d = 1'b0;
    cand_d   = cand_q;
    match_d  = match_q;
    miss_d   = miss_q;

    unique case (state_q)
      SILENT: begin
        if (rise) begin
          state_d = ARMED;
        end
      end

      ARMED: begin
        if (rise) begin
          period_d = meas;
          if ((cls == cand_q) && (match_q != '0)) begin
            match_d = match_q + 8'd1;
          end else if (cls != NOTE_NONE) begin
            cand_d  = cls;
            match_d = 8'd1;
          end else begin
            match_d = '0;
          end
          if (match_d == LOCK_N) begin
            state_d  = LOCKED;
            valid_d  = 1'b1;
            idx_d    = cand_d;
            change_d = !valid_q || (idx_q != cand_d);
          end
        end else if (counter_q == TMO) begin
          state_d = SILENT;
          valid_d = 1'b0;
          match_d = '0;
          miss_d  = '0;
        end
      end

      LOCKED: begin
        if (rise) begin
          period_d = meas;
          if (cls == idx_q) begin
            miss_d = '0;
          end else begin
            miss_d = miss_q + 8'd1;
          end
          if (miss_d == UNLOCK_N) begin
            state_d = ARMED;
            valid_d = 1'b0;
            miss_d  = '0;
            cand_d  = cls;
            match_d = (cls != NOTE_NONE) ? 8'd1 : 8'd0;
          end
        end else if (counter_q == TMO) begin
          state_d = SILENT;
          valid_d = 1'b0;
          match_d = '0;
          miss_d  = '0;
        end
      end

      default: begin
        state_d = SILENT;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SILENT;
      counter_q <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      idx_q     <= NOTE_C4;
      change_q  <= 1'b0;
      cand_q    <= NOTE_C4;
      match_q   <= '0;
      miss_q    <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      change_q  <= change_d;
      cand_q    <= cand_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
    end
  end

  assign bus.note_valid  = valid_q;
  assign bus.note_idx    = idx_q;
  assign bus.period      = period_q;
  assign bus.note_change = change_q;

endmodule

// File: tb/tb_note_detector.sv
// Self-checking bench for note_detector: boundary table, directed
// sequences and randomized periods against a rise-level reference model.
module tb_note_detector;

  localparam int TOL_C     = 2048;
  localparam int TIMEOUT_C = 200000;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #10 clk = ~clk;

  note_detector_if #(.CNT_W(18)) bus ();

  note_detector #(
    .LOCK_COUNT   (3),
    .UNLOCK_COUNT (2),
    .TOL          (TOL_C),
    .TIMEOUT      (TIMEOUT_C),
    .CNT_W        (18)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // note_change high-cycle count, sampled away from the active edge
  int pulse_total = 0;
  always @(negedge clk) begin
    if (bus.note_change) pulse_total <= pulse_total + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (one step per tone rise) -----------
  int ref_tab [12] = '{190840, 180506, 170070, 160772, 151516, 143268,
                       135136, 127552, 120482, 113638, 107298, 101216};
  bit m_timing;            // a first edge has been seen since silence/reset
  bit m_locked;
  int m_valid, m_idx, m_period, m_pulse;
  int m_cand, m_run, m_miss;

  function automatic int ref_class(input int p);
    for (int i = 0; i < 12; i++) begin
      int d;
      d = p - ref_tab[i];
      if (d < 0) d = -d;
      if (d <= TOL_C) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_timing = 0; m_locked = 0;
    m_valid = 0; m_idx = 0; m_period = 0; m_pulse = 0;
    m_cand = 0; m_run = 0; m_miss = 0;
  endtask

  task automatic model_rise(input int p);
    int c;
    m_pulse = 0;
    if (!m_timing) begin
      m_timing = 1;
      return;
    end
    m_period = p;
    c = ref_class(p);
    if (!m_locked) begin
      if (m_run > 0 && c == m_cand) m_run++;
      else if (c >= 0) begin m_cand = c; m_run = 1; end
      else m_run = 0;
      if (m_run == 3) begin
        m_pulse  = (m_valid == 0 || m_idx != m_cand) ? 1 : 0;
        m_locked = 1;
        m_valid  = 1;
        m_idx    = m_cand;
      end
    end else begin
      m_miss = (c == m_idx) ? 0 : m_miss + 1;
      if (m_miss == 2) begin
        m_locked = 0;
        m_valid  = 0;
        m_miss   = 0;
        m_cand   = c;
        m_run    = (c >= 0) ? 1 : 0;
      end
    end
  endtask

  task automatic model_timeout();
    if (m_timing) begin
      m_timing = 0; m_locked = 0;
      m_valid = 0; m_run = 0; m_miss = 0;
    end
  endtask

  // ---------------- stimulus ---------------------------------------------
  int last_len = 0;
  int last_pulses = 0;

  task automatic compare_model(input string tag);
    check({tag, ".valid"}, int'(bus.note_valid), m_valid);
    check({tag, ".idx"}, int'(bus.note_idx), m_idx);
    check({tag, ".period"}, int'(bus.period), m_period);
  endtask

  task automatic do_reset();
    bus.tone_in = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    last_len = 0;
  endtask

  // One square-wave cycle starting with a rise; checks outputs 8 clocks in
  task automatic wave(input int hi, input int lo);
    int base;
    base = pulse_total;
    bus.tone_in = 1'b1;
    model_rise(last_len);
    repeat (8) @(negedge clk);
    last_pulses = pulse_total - base;
    compare_model("wave");
    check("wave.change", last_pulses, m_pulse);
    repeat (hi - 8) @(negedge clk);
    bus.tone_in = 1'b0;
    repeat (lo) @(negedge clk);
    last_len = hi + lo;
  endtask

  task automatic wave_p(input int per);
    wave(per / 2, per - per / 2);
  endtask

  typedef struct {
    int per;
    int valid;
    int idx;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int cur, per;

    vecs[0] = '{192888, 1, 0};   // C4 + TOL
    vecs[1] = '{192889, 0, 0};   // C4 + TOL + 1
    vecs[2] = '{99168,  1, 11};  // B4 - TOL
    vecs[3] = '{99167,  0, 0};   // B4 - TOL - 1
    vecs[4] = '{109346, 1, 10};  // A#4 + TOL
    vecs[5] = '{111590, 1, 9};   // A4 - TOL

    bus.tone_in = 1'b0;
    do_reset();
    check("reset.valid", int'(bus.note_valid), 0);
    check("reset.idx", int'(bus.note_idx), 0);
    check("reset.period", int'(bus.period), 0);
    check("reset.change", pulse_total, 0);

    // Tolerance boundaries: three measured periods, judged at the 4th rise
    for (int v = 0; v < 6; v++) begin
      do_reset();
      repeat (4) wave_p(vecs[v].per);
      check("tab.valid", int'(bus.note_valid), vecs[v].valid);
      check("tab.idx", int'(bus.note_idx), vecs[v].idx);
      check("tab.period", int'(bus.period), vecs[v].per);
    end

    // A#4 lock, then switch to B4
    do_reset();
    repeat (3) wave(53649, 53649);
    check("as4.prelock", int'(bus.note_valid), 0);
    wave(53649, 53649);
    check("as4.valid", int'(bus.note_valid), 1);
    check("as4.idx", int'(bus.note_idx), 10);
    check("as4.period", int'(bus.period), 107298);
    check("as4.change", last_pulses, 1);
    wave(50608, 50608);
    check("b4.hold", int'(bus.note_valid), 1);
    wave(50608, 50608);
    check("b4.hold1", int'(bus.note_valid), 1);
    wave(50608, 50608);
    check("b4.drop", int'(bus.note_valid), 0);
    wave(50608, 50608);
    check("b4.wait", int'(bus.note_valid), 0);
    wave(50608, 50608);
    check("b4.valid", int'(bus.note_valid), 1);
    check("b4.idx", int'(bus.note_idx), 11);
    check("b4.change", last_pulses, 1);

    // C4 lock then silence
    do_reset();
    repeat (4) wave(95420, 95420);
    check("c4.idx", int'(bus.note_idx), 0);
    bus.tone_in = 1'b1;
    model_rise(last_len);
    repeat (95420) @(negedge clk);
    bus.tone_in = 1'b0;
    repeat (TIMEOUT_C - 95420) @(negedge clk);
    check("tmo.before", int'(bus.note_valid), 1);
    repeat (8) @(negedge clk);
    model_timeout();
    check("tmo.valid", int'(bus.note_valid), 0);
    check("tmo.period", int'(bus.period), 190840);
    compare_model("tmo");
    repeat (200) @(negedge clk);
    last_len = 0;
    wave(95420, 95420);          // first edge after silence only re-arms
    check("tmo.rearm", int'(bus.note_valid), 0);

    // Off-table period never locks
    do_reset();
    repeat (6) wave(55000, 55000);
    check("off.valid", int'(bus.note_valid), 0);
    check("off.period", int'(bus.period), 110000);

    // Jittered A4 with one injected G#4 period
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) wave(57569, 57569);
      else wave(56069, 56069);
    end
    check("a4.valid", int'(bus.note_valid), 1);
    check("a4.idx", int'(bus.note_idx), 9);
    wave(60241, 60241);
    wave(56819, 56819);
    check("a4.inj", int'(bus.note_valid), 1);
    check("a4.injp", int'(bus.period), 120482);
    wave(56819, 56819);
    check("a4.keep", int'(bus.note_valid), 1);
    check("a4.keepidx", int'(bus.note_idx), 9);

    // Reset while locked on G4, wave keeps running
    do_reset();
    repeat (4) wave(63776, 63776);
    check("g4.idx", int'(bus.note_idx), 7);
    bus.tone_in = 1'b1;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("rst.valid", int'(bus.note_valid), 0);
    check("rst.idx", int'(bus.note_idx), 0);
    check("rst.period", int'(bus.period), 0);
    repeat (63776 - 21) @(negedge clk);
    bus.tone_in = 1'b0;
    repeat (63776) @(negedge clk);
    last_len = 0;
    repeat (3) wave(63776, 63776);
    check("rst.wait", int'(bus.note_valid), 0);
    wave(63776, 63776);
    check("rst.relock", int'(bus.note_valid), 1);
    check("rst.relockidx", int'(bus.note_idx), 7);

    // Randomized periods around table entries, with occasional wild values
    do_reset();
    cur = $urandom_range(0, 11);
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 4) == 0) cur = $urandom_range(0, 11);
      if ($urandom_range(0, 7) == 0) per = $urandom_range(100000, 195000);
      else per = ref_tab[cur] + $urandom_range(0, 5000) - 2500;
      wave_p(per);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
